matrix_result_streamer: RTL and testbench

// Reader side of the result matrix memory: after the MAC controller finishes writing R,

---
 rtl/mm_pkg.sv | 23 ++
 rtl/matrix_result_streamer_if.sv | 36 +++
 rtl/stream_skid_fifo.sv | 67 ++++++
 rtl/matrix_result_streamer.sv | 136 +++++++++++++
 tb/tb_matrix_result_streamer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the result-matrix reader path.
package mm_pkg;

  localparam int unsigned SIZE_DEFAULT  = 4;
  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } st_e;

  // Row of a row-major linear element index.
  function automatic int unsigned idx_row(input int unsigned idx, input int unsigned size);
    return idx / size;
  endfunction

  // Column of a row-major linear element index.
  function automatic int unsigned idx_col(input int unsigned idx, input int unsigned size);
    return idx % size;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Element stream from the result reader towards the egress path.
interface matrix_result_streamer_if
  import mm_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  localparam int unsigned ADDR_W = $clog2(SIZE * SIZE);

  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [ADDR_W-1:0] m_row;
  logic [ADDR_W-1:0] m_col;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_col,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_col,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry output FIFO; the head entry is a register that drives the stream directly.
module stream_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop_ok;
  logic         push_ok;

  // Entry and occupancy update; pops on an empty FIFO and pushes into a full one are dropped.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head_data = head_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/matrix_result_streamer.sv
// Reads the result matrix row-major through a 1-cycle sync-read port and streams it out.
module matrix_result_streamer
  import mm_pkg::*;
#(
  parameter  int unsigned SIZE   = SIZE_DEFAULT,
  parameter  int unsigned WIDTH  = WIDTH_DEFAULT,
  localparam int unsigned ADDR_W = $clog2(SIZE * SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  matrix_result_streamer_if.master m
);

  localparam int unsigned       PAY_W     = WIDTH + 2 * ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE * SIZE - 1);

  st_e               state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] tag_row_q, tag_row_d;
  logic [ADDR_W-1:0] tag_col_q, tag_col_d;
  logic              tag_last_q, tag_last_d;

  logic              issue_c;
  logic              pop_c;
  logic              credit_ok_c;
  logic [2:0]        used_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAY_W-1:0]  push_data_c;
  logic [PAY_W-1:0]  head_data;
  logic [WIDTH-1:0]  head_elem;
  logic [ADDR_W-1:0] head_row;
  logic [ADDR_W-1:0] head_col;
  logic              head_last;

  // Credit: buffered plus in-flight reads, less this cycle's pop, must leave room for one more.
  always_comb begin
    pop_c       = !fifo_empty && m.m_ready;
    used_c      = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1)) + 3'(rd_pend_q);
    credit_ok_c = (used_c < (3'd2 + 3'(pop_c)));
  end

  // Sequencing FSM, address issue and tag capture for the read in flight.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    addr_d     = addr_q;
    rd_pend_d  = 1'b0;
    tag_row_d  = tag_row_q;
    tag_col_d  = tag_col_q;
    tag_last_d = tag_last_q;
    issue_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) state_d = ST_READ;
      end
      ST_READ: begin
        issue_c = credit_ok_c;
        if (issue_c && (addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop_c && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue_c) begin
      addr_d     = addr_q + ADDR_W'(1);
      rd_pend_d  = 1'b1;
      tag_row_d  = ADDR_W'(idx_row(32'(addr_q), SIZE));
      tag_col_d  = ADDR_W'(idx_col(32'(addr_q), SIZE));
      tag_last_d = (addr_q == LAST_ADDR);
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Control and read-tracking registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      rd_pend_q  <= rd_pend_d;
      tag_row_q  <= tag_row_d;
      tag_col_q  <= tag_col_d;
      tag_last_q <= tag_last_d;
    end
  end

  assign push_data_c = {mem_rdata, tag_row_q, tag_col_q, tag_last_q};

  stream_skid_fifo #(
    .W (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_data (push_data_c),
    .pop       (pop_c),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_elem, head_row, head_col, head_last} = head_data;

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign m.m_valid = !fifo_empty;
  assign m.m_data  = head_elem;
  assign m.m_row   = head_row;
  assign m.m_col   = head_col;
  assign m.m_last  = head_last;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench: random backpressure and contents against a row-major queue model.
module tb_matrix_result_streamer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, busy, done;
  logic [3:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        start2, busy2, done2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_rdata2;

  matrix_result_streamer_if #(.SIZE(4), .WIDTH(16)) s1 ();
  matrix_result_streamer_if #(.SIZE(2), .WIDTH(32)) s2 ();

  always #5 clk = ~clk;

  matrix_result_streamer #(.SIZE(4), .WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .m         (s1)
  );

  matrix_result_streamer #(.SIZE(2), .WIDTH(32)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .busy      (busy2),
    .done      (done2),
    .mem_addr  (mem_addr2),
    .mem_rdata (mem_rdata2),
    .m         (s2)
  );

  // Synchronous-read result memories.
  logic [15:0] rmem  [16];
  logic [31:0] rmem2 [4];
  always @(posedge clk) mem_rdata  <= rmem[mem_addr];
  always @(posedge clk) mem_rdata2 <= rmem2[mem_addr2];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state for the 4x4 instance.
  beat_t       exp_q[$];
  int          beats = 0, done_cnt = 0, cyc = 0, done_cyc = -1, last_beat_cyc = -2, max_ahead = 0;
  bit          prev_stall = 0;
  logic [24:0] prev_pay;

  // Output monitor for the 4x4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    logic [24:0] pay;
    beat_t       e;
    int          ahead;
    cyc++;
    pay = {s1.m_data, s1.m_row, s1.m_col, s1.m_last};
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(s1.m_valid), 64'd1);
        check("stall_hold", 64'(pay), 64'(prev_pay));
      end
      ahead = int'(mem_addr) - beats;
      if (busy && ahead > max_ahead) max_ahead = ahead;
      if (s1.m_valid && s1.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(pay), 64'h1_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(pay), 64'(e));
        end
        beats++;
        last_beat_cyc = cyc;
      end
      prev_stall = s1.m_valid && !s1.m_ready;
      prev_pay   = pay;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_on_done", 64'(busy), 64'd0);
      end
    end
  end

  // Output monitor for the 2x2 instance.
  int beats2 = 0, done2_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (s2.m_valid && s2.m_ready) begin
        if (beats2 < 4)
          check("beat2", 64'({s2.m_data, s2.m_row, s2.m_col, s2.m_last}),
                64'({rmem2[beats2], 2'(beats2 / 2), 2'(beats2 % 2), beats2 == 3}));
        else
          check("unexpected_beat2", 64'(s2.m_data), 64'h1_0000_0000);
        beats2++;
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expected();
    beat_t e;
    exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      e.d = rmem[n];
      e.r = 4'(n / 4);
      e.c = 4'(n % 4);
      e.l = (n == 15);
      exp_q.push_back(e);
    end
    beats = 0; done_cnt = 0; max_ahead = 0; done_cyc = -1; last_beat_cyc = -2;
  endtask

  // mode: 0 ready high, 1 ready 1,0,0,1 repeating, 2 random ready, 3 ready low for 20 cycles.
  task automatic run_stream(input string name, input int mode, input bit repulse);
    bit seen;
    bit p5;
    seen = 0;
    p5   = 0;
    load_expected();
    s1.m_ready = (mode != 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = -1;
    check({name, ":busy_after_start"}, 64'(busy), 64'd1);
    for (int k = 0; k < 400 && !seen; k++) begin
      if (mode == 3 && k == 20) begin
        check({name, ":stall_valid"}, 64'(s1.m_valid), 64'd1);
        check({name, ":stall_head"}, 64'({s1.m_data, s1.m_row, s1.m_col, s1.m_last}),
              64'({rmem[0], 4'd0, 4'd0, 1'b0}));
        check({name, ":stall_reads"}, 64'(mem_addr), 64'd2);
        check({name, ":stall_beats"}, 64'(beats), 64'd0);
      end
      case (mode)
        0:       s1.m_ready = 1'b1;
        1:       s1.m_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       s1.m_ready = ($urandom_range(0, 3) != 0);
        3:       s1.m_ready = (k >= 20);
        default: s1.m_ready = 1'b1;
      endcase
      start = repulse && (beats == 5) && !p5;
      if (start) p5 = 1;
      tick();
      start = 1'b0;
      seen  = done;
    end
    check({name, ":done_seen"}, 64'(seen), 64'd1);
    if (repulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat (repulse ? 25 : 3) tick();
    check({name, ":beats"}, 64'(beats), 64'd16);
    check({name, ":done_count"}, 64'(done_cnt), 64'd1);
    check({name, ":done_after_last"}, 64'(done_cyc), 64'(last_beat_cyc + 1));
    check({name, ":model_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, ":addr_ahead_le2"}, 64'(max_ahead <= 2), 64'd1);
    check({name, ":idle_busy"}, 64'(busy), 64'd0);
    if (mode == 0) check({name, ":start_to_done"}, 64'(done_cyc), 64'd18);
  endtask

  initial begin
    bit seen2;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    s1.m_ready = 1'b0; s2.m_ready = 1'b0;
    for (int n = 0; n < 16; n++) rmem[n] = 16'(n * 3);
    rmem2[0] = 32'hFFFF_FFFF; rmem2[1] = 32'd1; rmem2[2] = 32'd2; rmem2[3] = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(s1.m_valid), 64'd0);
    check("rst_payload", 64'({s1.m_data, s1.m_row, s1.m_col, s1.m_last}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_valid2", 64'(s2.m_valid), 64'd0);
    reset = 1'b0;
    tick();

    run_stream("full_rate", 0, 0);
    run_stream("toggle", 1, 0);
    run_stream("stall20", 3, 0);
    run_stream("restart_ignored", 0, 1);

    // Reset in the middle of a stream.
    load_expected();
    s1.m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && beats < 7; k++) tick();
    check("abort:reached_beat7", 64'(beats), 64'd7);
    reset = 1'b1;
    #1;
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:done", 64'(done), 64'd0);
    check("abort:valid", 64'(s1.m_valid), 64'd0);
    check("abort:payload", 64'({s1.m_data, s1.m_row, s1.m_col, s1.m_last}), 64'd0);
    check("abort:addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (25) tick();
    check("abort:no_done", 64'(done_cnt), 64'd0);
    check("abort:no_more_beats", 64'(beats), 64'd7);
    check("abort:idle", 64'(busy), 64'd0);
    run_stream("after_reset", 0, 0);

    // Random contents under random backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < 16; n++) rmem[n] = 16'($urandom);
      run_stream("random", 2, 0);
    end

    // 2x2, 32-bit instance.
    s2.m_ready = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    seen2 = 0;
    for (int k = 0; k < 40 && !seen2; k++) begin
      tick();
      seen2 = done2;
    end
    repeat (3) tick();
    check("size2:done_seen", 64'(seen2), 64'd1);
    check("size2:beats", 64'(beats2), 64'd4);
    check("size2:done_count", 64'(done2_cnt), 64'd1);
    check("size2:idle", 64'(busy2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
